program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter IMEM_WORDS, default 256, number of 32-bit words in instruction memory; legal range 1..256.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse to begin a load session; honoured only in IDLE or DONE.
REQ-005 rx_valid  input  1  byte-stream source has a byte on rx_data.
REQ-006 rx_data  input  8  byte from host serial receiver.
REQ-007 rx_ready  output  1  loader accepts the byte; transfer occurs when rx_valid and rx_ready are both high on a rising edge.
REQ-008 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 imem_addr  output  10  byte address of the word being written, always word-aligned (bits[1:0] = 0).
REQ-010 imem_wdata  output  32  assembled instruction word.
REQ-011 cpu_reset  output  1  held-high reset to the processor core while loading; low only in DONE.
REQ-012 done  output  1  high in DONE state.
REQ-013 error  output  1  high in ERR state.

Function
REQ-014 FSM states: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR; encoding binary.
REQ-015 IDLE: rx_ready=0, cpu_reset=1; start -> LEN_LO.
REQ-016 LEN_LO: rx_ready=1; accepted byte -> word count bits[7:0]; -> LEN_HI.
REQ-017 LEN_HI: rx_ready=1; accepted byte -> count bits[15:8]; count 0 or >IMEM_WORDS -> ERR, else -> DATA, word index = 0, byte index = 0.
REQ-018 DATA: rx_ready=1; bytes little-endian (first byte -> bits[7:0]); after 4th byte -> WRITE.
REQ-019 WRITE: rx_ready=0; imem_we=1 for exactly one cycle, imem_addr = word index * 4, imem_wdata = assembled word; word index increments; if incremented index equals count -> DONE, else -> DATA.
REQ-020 Latency: imem_we asserts the cycle after the 4th byte of a word is accepted.
REQ-021 DONE: cpu_reset=0 on the same edge the state enters DONE; rx_ready=0; bytes offered are ignored; start -> LEN_LO with cpu_reset=1 again.
REQ-022 ERR: cpu_reset=1, rx_ready=0, error=1; exits only via reset.
REQ-023 start in LEN_LO/LEN_HI/DATA/WRITE ignored; rx_valid low stalls any state without side effects.
REQ-024 Word index is 9 bits; a count of exactly IMEM_WORDS writes the last address (IMEM_WORDS-1)*4 with no wrap.
REQ-025 imem_we, imem_addr, imem_wdata are registered; imem_addr/imem_wdata hold last written value when imem_we=0.

Reset
REQ-026 Reset forces IDLE, cpu_reset=1, rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, done=0, error=0, counters=0.
REQ-027 Reset mid-load aborts immediately; partially assembled word is discarded, no write issued.

Structure
REQ-028 Shared package holds the FSM state typedef, IMEM_WORDS default, and the 16-bit count width constant.
REQ-029 One sub-module, byte_packer (shifts 4 bytes into a 32-bit little-endian word, reports word_full); FSM and counters stay in program_loader.

Verification
REQ-030 Reset, start, bytes 02 00 13 00 50 00 93 00 A0 00 -> writes 0x00500013 @0x000, 0x00A00093 @0x004, then done=1, cpu_reset=0.
REQ-031 Count bytes 00 00 -> error=1, cpu_reset=1, no imem_we ever; only reset clears it.
REQ-032 Count 0x0101 (257) with IMEM_WORDS=256 -> ERR; count 0x0100 -> 256 writes, last @0x3FC, then DONE.
REQ-033 rx_valid toggled randomly mid-word for a 3-word load -> identical writes and order as gap-free stream.
REQ-034 reset asserted after 2 data bytes of word 1 -> outputs return to reset values same cycle; fresh start reloads correctly.
REQ-035 In DONE, extra bytes and start-less traffic -> no writes; a new start reasserts cpu_reset and a second load overwrites from address 0.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the serial program loader.
package program_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  localparam int IMEM_WORDS_DEFAULT = 256;
  localparam int COUNT_W            = 16;
  localparam int WIDX_W             = 9;

  // Word index to word-aligned byte address.
  function automatic logic [9:0] word_byte_addr(input logic [7:0] idx);
    return {idx, 2'b00};
  endfunction

endpackage

// File: rtl/program_loader_byte_packer.sv
// Shifts four bytes into a little-endian 32-bit word; word_full marks the completing byte.
module byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_full
);

  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;

  // Next-state for the shift register and byte counter.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear) begin
      word_d = 32'd0;
      cnt_d  = 2'd0;
    end else if (shift_en) begin
      word_d = {byte_in, word_q[31:8]};
      cnt_d  = cnt_q + 2'd1;
    end else begin
      word_d = word_q;
      cnt_d  = cnt_q;
    end
  end

  // First byte ends up in bits [7:0] after four right-shifts.
  assign word_next = {byte_in, word_q[31:8]};
  assign word_full = shift_en & (cnt_q == 2'd3);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q <= 32'd0;
      cnt_q  <= 2'd0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory,
// holding the CPU in reset until the whole image has been written.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int IMEM_WORDS = IMEM_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [9:0]  imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  localparam logic [COUNT_W-1:0] MAX_COUNT = COUNT_W'(IMEM_WORDS);

  state_t              state_q, state_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic [WIDX_W-1:0]   word_idx_q, word_idx_d;
  logic                imem_we_q, imem_we_d;
  logic [9:0]          imem_addr_q, imem_addr_d;
  logic [31:0]         imem_wdata_q, imem_wdata_d;
  logic                rx_ready_q, rx_ready_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic                rx_fire_s;
  logic [COUNT_W-1:0]  len_s;
  logic [WIDX_W-1:0]   widx_inc_s;
  logic                pk_clear_s;
  logic                pk_shift_s;
  logic [31:0]         pk_word_s;
  logic                pk_full_s;

  assign rx_fire_s  = rx_valid & rx_ready_q;
  assign len_s      = {rx_data, count_q[7:0]};
  assign widx_inc_s = word_idx_q + 9'd1;

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (pk_clear_s),
    .shift_en  (pk_shift_s),
    .byte_in   (rx_data),
    .word_next (pk_word_s),
    .word_full (pk_full_s)
  );

  // Next-state, counters and write-port values; status outputs decode the next state.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    word_idx_d   = word_idx_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    pk_clear_s   = 1'b0;
    pk_shift_s   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LEN_LO;
        end else begin
          state_d = state_q;
        end
      end
      ST_LEN_LO: begin
        if (rx_fire_s) begin
          count_d = {8'd0, rx_data};
          state_d = ST_LEN_HI;
        end else begin
          state_d = ST_LEN_LO;
        end
      end
      ST_LEN_HI: begin
        if (rx_fire_s) begin
          count_d = len_s;
          if ((len_s == 16'd0) || (len_s > MAX_COUNT)) begin
            state_d = ST_ERR;
          end else begin
            state_d    = ST_DATA;
            word_idx_d = 9'd0;
            pk_clear_s = 1'b1;
          end
        end else begin
          state_d = ST_LEN_HI;
        end
      end
      ST_DATA: begin
        if (rx_fire_s) begin
          pk_shift_s = 1'b1;
          if (pk_full_s) begin
            // Write port is loaded here so imem_we is high during WRITE.
            state_d      = ST_WRITE;
            imem_we_d    = 1'b1;
            imem_addr_d  = word_byte_addr(word_idx_q[7:0]);
            imem_wdata_d = pk_word_s;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_WRITE: begin
        word_idx_d = widx_inc_s;
        if ({7'd0, widx_inc_s} == count_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_ERR;
      end
    endcase

    rx_ready_d  = (state_d == ST_LEN_LO) || (state_d == ST_LEN_HI) || (state_d == ST_DATA);
    cpu_reset_d = (state_d != ST_DONE);
    done_d      = (state_d == ST_DONE);
    error_d     = (state_d == ST_ERR);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      count_q      <= 16'd0;
      word_idx_q   <= 9'd0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= 10'd0;
      imem_wdata_q <= 32'd0;
      rx_ready_q   <= 1'b0;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      word_idx_q   <= word_idx_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      rx_ready_q   <= rx_ready_d;
      cpu_reset_q  <= cpu_reset_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign rx_ready   = rx_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader against a stream-level write model.
module tb_program_loader;

  localparam int W = 256;

  logic        clk;
  logic        reset;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;

  program_loader #(.IMEM_WORDS(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  stream[$];
  logic [41:0] exp_q[$];
  logic [41:0] wr_log[$];
  logic [41:0] log_a[$];
  logic [41:0] last_exp;
  logic [41:0] e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Model: expected writes follow directly from the byte stream.
  function automatic bit build_expect();
    int cnt;
    logic [9:0]  a;
    logic [31:0] d;
    cnt = int'(stream[0]) | (int'(stream[1]) << 8);
    if (cnt == 0 || cnt > W) return 1'b1;
    for (int i = 0; i < cnt; i++) begin
      a = 10'(i * 4);
      d = {stream[2+4*i+3], stream[2+4*i+2], stream[2+4*i+1], stream[2+4*i]};
      exp_q.push_back({a, d});
    end
    return 1'b0;
  endfunction

  task automatic make_stream(input int cnt, input int nwords);
    stream.delete();
    stream.push_back(cnt[7:0]);
    stream.push_back(cnt[15:8]);
    for (int i = 0; i < 4 * nwords; i++) stream.push_back(8'($urandom));
  endtask

  // Compare process: every write popped against the model, hold values otherwise.
  always @(negedge clk) begin
    if (!reset) begin
      chk("cpu_reset_vs_done", {63'd0, cpu_reset}, {63'd0, ~done});
      chk("addr_aligned", {62'd0, imem_addr[1:0]}, 64'd0);
      if (imem_we) begin
        wr_log.push_back({imem_addr, imem_wdata});
        if (exp_q.size() == 0) begin
          chk("spurious_we", {63'd0, imem_we}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", {54'd0, imem_addr}, {54'd0, e[41:32]});
          chk("wr_data", {32'd0, imem_wdata}, {32'd0, e[31:0]});
          last_exp = e;
        end
      end else begin
        chk("hold_addr", {54'd0, imem_addr}, {54'd0, last_exp[41:32]});
        chk("hold_data", {32'd0, imem_wdata}, {32'd0, last_exp[31:0]});
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset    = 1'b1;
    rx_valid = 1'b0;
    start    = 1'b0;
    exp_q.delete();
    last_exp = 42'd0;
    #1;
    chk("rst_rx_ready", {63'd0, rx_ready}, 64'd0);
    chk("rst_cpu_reset", {63'd0, cpu_reset}, 64'd1);
    chk("rst_we", {63'd0, imem_we}, 64'd0);
    chk("rst_addr", {54'd0, imem_addr}, 64'd0);
    chk("rst_wdata", {32'd0, imem_wdata}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_error", {63'd0, error}, 64'd0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Offers one byte, optionally after random idle cycles with stray start pulses.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    n = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        start    = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
    end
    start    = 1'b0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("rx_ready_timeout", {63'd0, rx_ready}, 64'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_load(input bit gaps, output bit err_exp);
    err_exp = build_expect();
    pulse_start();
    chk("cpu_reset_on_start", {63'd0, cpu_reset}, 64'd1);
    chk("rx_ready_len_lo", {63'd0, rx_ready}, 64'd1);
    chk("done_cleared", {63'd0, done}, 64'd0);
    for (int i = 0; i < stream.size(); i++) begin
      send_byte(stream[i], gaps);
      if (i >= 2 && ((i - 2) % 4) == 3) chk("we_latency", {63'd0, imem_we}, 64'd1);
    end
    repeat (2) @(negedge clk);
    chk("end_done", {63'd0, done}, {63'd0, ~err_exp});
    chk("end_error", {63'd0, error}, {63'd0, err_exp});
    chk("end_cpu_reset", {63'd0, cpu_reset}, {63'd0, err_exp});
    chk("end_rx_ready", {63'd0, rx_ready}, 64'd0);
    chk("pending_writes", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    bit err;
    int nlog;
    reset    = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    last_exp = 42'd0;

    do_reset();

    // Basic two-word image with literal expectations.
    stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
    err = build_expect();
    chk("model_w0", {22'd0, exp_q[0]}, {22'd0, 10'h000, 32'h00500013});
    chk("model_w1", {22'd0, exp_q[1]}, {22'd0, 10'h004, 32'h00A00093});
    exp_q.delete();
    run_load(1'b0, err);

    // DONE ignores traffic; a restart overwrites from address 0.
    wr_log.delete();
    repeat (6) begin
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    chk("done_no_writes", 64'(wr_log.size()), 64'd0);
    chk("done_holds", {63'd0, done}, 64'd1);
    make_stream(2, 2);
    run_load(1'b1, err);
    chk("reload_from_0", {54'd0, wr_log[0][41:32]}, 64'd0);

    // Zero count -> ERR, sticky until reset.
    stream = '{8'h00, 8'h00};
    run_load(1'b0, err);
    chk("model_err0", {63'd0, err}, 64'd1);
    pulse_start();
    repeat (4) begin
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    chk("err_sticky", {63'd0, error}, 64'd1);
    chk("err_cpu_reset", {63'd0, cpu_reset}, 64'd1);
    do_reset();

    // Count 257 -> ERR; count 256 -> full memory.
    stream = '{8'h01, 8'h01};
    run_load(1'b0, err);
    do_reset();
    wr_log.delete();
    make_stream(256, 256);
    run_load(1'b0, err);
    chk("full_count", 64'(wr_log.size()), 64'd256);
    nlog = wr_log.size();
    if (nlog > 0) chk("full_last_addr", {54'd0, wr_log[nlog-1][41:32]}, 64'h3FC);

    // Same 3-word image with and without flow-control gaps.
    make_stream(3, 3);
    wr_log.delete();
    run_load(1'b0, err);
    log_a = wr_log;
    wr_log.delete();
    run_load(1'b1, err);
    chk("gap_log_size", 64'(wr_log.size()), 64'(log_a.size()));
    for (int i = 0; i < log_a.size() && i < wr_log.size(); i++)
      chk("gap_log_entry", {22'd0, wr_log[i]}, {22'd0, log_a[i]});

    // Reset after two data bytes of the first word, then a fresh load.
    make_stream(2, 2);
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(stream[i], 1'b0);
    do_reset();
    make_stream(3, 3);
    run_load(1'b1, err);

    // Random loads back to back from DONE.
    for (int k = 0; k < 4; k++) begin
      int n;
      n = $urandom_range(1, 8);
      make_stream(n, n);
      run_load(1'b1, err);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
